// File: rtl/pcpi_cgra_pkg.sv
// Shared types and constants for the PCPI-to-CGRA bridge: FSM states,
// custom instruction funct3 codes, array operation codes and the abort value.
package pcpi_cgra_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        RESP  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [2:0] FUNCT3_CFG    = 3'b000;
    localparam logic [2:0] FUNCT3_RUN    = 3'b001;
    localparam logic [2:0] FUNCT3_STATUS = 3'b010;

    localparam logic [1:0] CGRA_OP_NONE = 2'b00;
    localparam logic [1:0] CGRA_OP_CFG  = 2'b01;
    localparam logic [1:0] CGRA_OP_RUN  = 2'b10;

    localparam logic [31:0] ERR_VALUE = 32'hFFFF_FFFF;

    // STATUS word: completed-RUN count in the upper half, sticky error in bit 0.
    function automatic logic [31:0] status_word(input logic [15:0] run_count, input logic err);
        return {run_count, 15'b0, err};
    endfunction

endpackage

// File: rtl/pcpi_cgra_dec.sv
// Combinational decoder for the CGRA custom instructions (CFG, RUN, STATUS).
// Anything outside the custom opcode with funct7 == 0 is left unmatched.
module pcpi_cgra_dec
    import pcpi_cgra_pkg::*;
#(
    parameter logic [6:0] CUSTOM_OPCODE = 7'b0001011
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       is_cfg,
    output logic       is_run,
    output logic       is_status
);

    always_comb begin
        is_cfg    = 1'b0;
        is_run    = 1'b0;
        is_status = 1'b0;
        if (opcode == CUSTOM_OPCODE && funct7 == 7'd0) begin
            case (funct3)
                FUNCT3_CFG:    is_cfg    = 1'b1;
                FUNCT3_RUN:    is_run    = 1'b1;
                FUNCT3_STATUS: is_status = 1'b1;
                default:       ;
            endcase
        end
    end

endmodule

// File: rtl/pcpi_cgra.sv
// PCPI coprocessor bridge that launches CFG/RUN operations on a CGRA array,
// bounds them with a timeout, and reports a run counter plus sticky error flag.
module pcpi_cgra
    import pcpi_cgra_pkg::*;
#(
    parameter logic [6:0] CUSTOM_OPCODE  = 7'b0001011,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        cgra_start,
    output logic [1:0]  cgra_op,
    output logic [31:0] cgra_a,
    output logic [31:0] cgra_b,
    input  logic        cgra_done,
    input  logic [31:0] cgra_result
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_next;
    logic [1:0]    op_q;
    logic [31:0]   a_q, b_q, rd_q;
    logic          wr_q;
    logic [15:0]   run_count;
    logic          err;
    logic [TW-1:0] tmo_cnt;

    logic is_cfg, is_run, is_status;
    logic launch, take_status, finish_ok, finish_tmo;

    // Register-address fields carry no meaning for these instructions.
    logic unused_insn;
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    pcpi_cgra_dec #(
        .CUSTOM_OPCODE(CUSTOM_OPCODE)
    ) u_dec (
        .opcode    (pcpi_insn[6:0]),
        .funct3    (pcpi_insn[14:12]),
        .funct7    (pcpi_insn[31:25]),
        .is_cfg    (is_cfg),
        .is_run    (is_run),
        .is_status (is_status)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        take_status = 1'b0;
        finish_ok   = 1'b0;
        finish_tmo  = 1'b0;
        case (state)
            IDLE: begin
                if (pcpi_valid && (is_cfg || is_run)) begin
                    launch     = 1'b1;
                    state_next = ISSUE;
                end else if (pcpi_valid && is_status) begin
                    take_status = 1'b1;
                    state_next  = RESP;
                end
            end
            ISSUE: state_next = BUSY;
            // A done arriving on the expiry cycle still wins over the abort.
            BUSY: begin
                if (cgra_done) begin
                    finish_ok  = 1'b1;
                    state_next = RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    finish_tmo = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q      <= CGRA_OP_NONE;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            wr_q      <= 1'b0;
            run_count <= '0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (launch) begin
                op_q    <= is_run ? CGRA_OP_RUN : CGRA_OP_CFG;
                a_q     <= pcpi_rs1;
                b_q     <= pcpi_rs2;
                tmo_cnt <= '0;
            end
            if (state == BUSY && !finish_ok && !finish_tmo) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (finish_ok) begin
                rd_q <= cgra_result;
                wr_q <= (op_q == CGRA_OP_RUN);
                if (op_q == CGRA_OP_RUN) begin
                    run_count <= run_count + 16'd1;
                end
            end
            if (finish_tmo) begin
                rd_q <= ERR_VALUE;
                wr_q <= (op_q == CGRA_OP_RUN);
                err  <= 1'b1;
            end
            if (take_status) begin
                rd_q <= status_word(run_count, err);
                wr_q <= 1'b1;
                err  <= 1'b0;
            end
        end
    end

    // Outputs decode from state so that reset silences them immediately.
    assign cgra_start = (state == ISSUE);
    assign pcpi_wait  = (state == ISSUE) || (state == BUSY);
    assign pcpi_ready = (state == RESP);
    assign pcpi_rd    = pcpi_ready ? rd_q : 32'd0;
    assign pcpi_wr    = pcpi_ready & wr_q;
    assign cgra_op    = pcpi_wait ? op_q : CGRA_OP_NONE;
    assign cgra_a     = pcpi_wait ? a_q : 32'd0;
    assign cgra_b     = pcpi_wait ? b_q : 32'd0;

endmodule

// File: tb/tb_pcpi_cgra.sv
// Directed self-checking bench for pcpi_cgra with a short timeout so that
// abort, same-edge completion, STATUS readback and reset recovery are reachable.
module tb_pcpi_cgra;

    logic        clk;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        cgra_start;
    logic [1:0]  cgra_op;
    logic [31:0] cgra_a;
    logic [31:0] cgra_b;
    logic        cgra_done;
    logic [31:0] cgra_result;

    int total_checks = 0;
    int bad_checks   = 0;
    int start_count  = 0;

    localparam logic [31:0] INSN_CFG    = 32'h0000_000B;
    localparam logic [31:0] INSN_RUN    = 32'h0000_100B;
    localparam logic [31:0] INSN_STATUS = 32'h0000_200B;
    localparam logic [31:0] INSN_BAD_F3 = 32'h0000_300B;
    localparam logic [31:0] INSN_BAD_F7 = 32'h0200_100B;

    pcpi_cgra #(
        .CUSTOM_OPCODE  (7'b0001011),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pcpi_valid  (pcpi_valid),
        .pcpi_insn   (pcpi_insn),
        .pcpi_rs1    (pcpi_rs1),
        .pcpi_rs2    (pcpi_rs2),
        .pcpi_wr     (pcpi_wr),
        .pcpi_rd     (pcpi_rd),
        .pcpi_wait   (pcpi_wait),
        .pcpi_ready  (pcpi_ready),
        .cgra_start  (cgra_start),
        .cgra_op     (cgra_op),
        .cgra_a      (cgra_a),
        .cgra_b      (cgra_b),
        .cgra_done   (cgra_done),
        .cgra_result (cgra_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cgra_start === 1'b1) start_count <= start_count + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] insn,
                                 input logic [31:0] rs1, input logic [31:0] rs2);
        pcpi_valid = valid;
        pcpi_insn  = insn;
        pcpi_rs1   = rs1;
        pcpi_rs2   = rs2;
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, "_wait"},  32'(pcpi_wait),  32'd0);
        checkOutput({tag, "_ready"}, 32'(pcpi_ready), 32'd0);
        checkOutput({tag, "_start"}, 32'(cgra_start), 32'd0);
        checkOutput({tag, "_rd"},    pcpi_rd,         32'd0);
    endtask

    // done_at: BUSY cycle (1-based) in which cgra_done is raised; 0 = never.
    task automatic do_op(input string tag, input logic [31:0] insn,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input int done_at, input logic [31:0] result,
                         input logic exp_wr, input logic [31:0] exp_rd,
                         input int exp_busy, input logic hold_valid);
        int          base;
        int          busy;
        logic        got_ready;
        logic [1:0]  exp_op;
        logic [2:0]  f3;
        f3     = insn[14:12];
        exp_op = (f3 == 3'b001) ? 2'b10 : 2'b01;
        base   = start_count;
        busy   = 0;
        got_ready = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, insn, rs1, rs2);
        @(negedge clk);
        checkOutput({tag, "_issue_start"}, 32'(cgra_start), 32'd1);
        checkOutput({tag, "_issue_wait"},  32'(pcpi_wait),  32'd1);
        checkOutput({tag, "_op"},          32'(cgra_op),    32'(exp_op));
        checkOutput({tag, "_a"},           cgra_a,          rs1);
        checkOutput({tag, "_b"},           cgra_b,          rs2);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (pcpi_ready === 1'b1) begin
                got_ready = 1'b1;
                break;
            end
            busy        = cyc;
            cgra_done   = (cyc == done_at);
            cgra_result = (cyc == done_at) ? result : 32'hDEAD_BEEF;
        end
        checkOutput({tag, "_ready"}, 32'(got_ready),  32'd1);
        checkOutput({tag, "_busy"},  32'(busy),       32'(exp_busy));
        checkOutput({tag, "_wr"},    32'(pcpi_wr),    32'(exp_wr));
        checkOutput({tag, "_rd"},    pcpi_rd,         exp_rd);
        checkOutput({tag, "_rwait"}, 32'(pcpi_wait),  32'd0);
        cgra_done   = 1'b0;
        cgra_result = 32'h0;
        if (!hold_valid) pcpi_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_hold_ready"}, 32'(pcpi_ready), 32'd0);
        checkOutput({tag, "_hold_rd"},    pcpi_rd,         32'd0);
        @(negedge clk);
        checkOutput({tag, "_idle_wait"}, 32'(pcpi_wait), 32'd0);
        pcpi_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_starts"}, 32'(start_count - base), 32'd1);
    endtask

    task automatic do_status(input string tag, input logic [31:0] exp_rd);
        @(negedge clk);
        applyStimulus(1'b1, INSN_STATUS, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput({tag, "_ready"}, 32'(pcpi_ready), 32'd1);
        checkOutput({tag, "_wr"},    32'(pcpi_wr),    32'd1);
        checkOutput({tag, "_rd"},    pcpi_rd,         exp_rd);
        checkOutput({tag, "_wait"},  32'(pcpi_wait),  32'd0);
        pcpi_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_hold"}, 32'(pcpi_ready), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int base;
        resetn      = 1'b0;
        cgra_done   = 1'b0;
        cgra_result = 32'h0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check_quiet("reset");
        checkOutput("reset_wr", 32'(pcpi_wr), 32'd0);
        checkOutput("reset_op", 32'(cgra_op), 32'd0);
        checkOutput("reset_a",  cgra_a,       32'd0);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("release_start", 32'(start_count), 32'd0);

        $display("[TB] RUN with done after three BUSY cycles");
        do_op("run1", INSN_RUN, 32'd5, 32'd7, 3, 32'h23, 1'b1, 32'h23, 3, 1'b0);
        do_status("stat1", 32'h0001_0000);

        $display("[TB] CFG with done after one cycle");
        do_op("cfg1", INSN_CFG, 32'h11, 32'h22, 1, 32'hABCD, 1'b0, 32'hABCD, 1, 1'b0);
        do_status("stat2", 32'h0001_0000);

        $display("[TB] RUN timeout and sticky error");
        do_op("tmo", INSN_RUN, 32'h1, 32'h2, 0, 32'h0, 1'b1, 32'hFFFF_FFFF, 4, 1'b0);
        do_status("stat_err", 32'h0001_0001);
        do_status("stat_clr", 32'h0001_0000);

        $display("[TB] done on the timeout edge");
        do_op("edge", INSN_RUN, 32'h3, 32'h4, 4, 32'h55, 1'b1, 32'h55, 4, 1'b0);
        do_status("stat3", 32'h0002_0000);

        $display("[TB] valid held through RESP and HOLD");
        do_op("held", INSN_RUN, 32'h9, 32'hA, 2, 32'h66, 1'b1, 32'h66, 2, 1'b1);

        $display("[TB] unmatched instructions and stray done");
        base = start_count;
        @(negedge clk);
        applyStimulus(1'b1, INSN_BAD_F3, 32'h1, 32'h1);
        repeat (3) begin
            @(negedge clk);
            check_quiet("bad_f3");
        end
        applyStimulus(1'b1, INSN_BAD_F7, 32'h1, 32'h1);
        @(negedge clk);
        check_quiet("bad_f7");
        applyStimulus(1'b0, INSN_RUN, 32'h1, 32'h1);
        cgra_done   = 1'b1;
        cgra_result = 32'h99;
        repeat (2) begin
            @(negedge clk);
            check_quiet("novalid_done");
        end
        cgra_done = 1'b0;
        checkOutput("unmatched_starts", 32'(start_count - base), 32'd0);

        $display("[TB] reset mid-BUSY");
        base = start_count;
        applyStimulus(1'b1, INSN_RUN, 32'h44, 32'h88);
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_wait", 32'(pcpi_wait), 32'd1);
        resetn = 1'b0;
        #1;
        check_quiet("mid_reset");
        checkOutput("mid_reset_op", 32'(cgra_op), 32'd0);
        checkOutput("mid_reset_a",  cgra_a,       32'd0);
        checkOutput("mid_reset_b",  cgra_b,       32'd0);
        pcpi_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_starts", 32'(start_count - base), 32'd1);
        do_op("after_rst", INSN_RUN, 32'h12, 32'h34, 2, 32'h77, 1'b1, 32'h77, 2, 1'b0);
        do_status("stat_rst", 32'h0001_0000);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
